riscv_lsu: RTL and testbench
============================

# riscv_lsu

Parametrised load/store unit between the RV32I execute/memory-access stage and the data-memory bus. It accepts one LOAD_C/STORE_C operation at a time, checks alignment, drives a valid/ready data-bus request with byte enables, waits for completion with a timeout, and returns sign- or zero-extended load data tagged with the destination register. Data width is fixed at 32 bits (`dataBus_t`). Address width and timeout are parameters, and misaligned-access trapping is a compile-time option.

## Interface
- ADDR_W, 32: byte-address width; legal range is 3 to 64.
- TIMEOUT_CYCLES, 255: maximum number of WAIT cycles before a bus error is forced; 0 disables the timeout.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  operation offered.
- req_ready  out  1  unit idle and able to accept an operation.
- req_store  in  1  1 = STORE_C, 0 = LOAD_C.
- req_funct3  in  3  `funct3ITypeLOAD_e` for loads, `funct3SType_e` for stores.
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  32  store data taken from rs2.
- req_rd  in  5  destination `regAddr_t`.
- resp_valid  out  1  result available.
- resp_ready  in  1  result consumed.
- resp_rdata  out  32  extended load data; 0 for stores and for errors.
- resp_rd  out  5  req_rd carried through.
- resp_err  out  1  bus error, timeout or illegal funct3.
- resp_misalign  out  1  misaligned-access trap.
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus accepts the request.
- mem_we  out  1  write.
- mem_addr  out  ADDR_W  word address; bits [1:0] are always 0.
- mem_be  out  4  byte enables; lane k is bits [8k+7:8k] (little-endian).
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  completion; carries read data for loads and acts as the write acknowledge for stores.
- mem_rdata  in  32  read data.
- mem_err  in  1  error qualifier, sampled with mem_rvalid.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Reset places the FSM in IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch store, funct3, addr, wdata and rd.
  - Illegal funct3 (load 011/110/111, store ≥011): go to RESP with resp_err=1.
  - Misaligned access with the trap enabled: go to RESP with resp_misalign=1.
  - Otherwise go to REQ.
- REQ:
  - mem_valid=1; mem_we, mem_addr, mem_be and mem_wdata are stable until mem_ready.
  - On mem_valid&mem_ready, go to WAIT and clear the timeout counter.
- WAIT:
  - On mem_rvalid, capture the data and mem_err, then go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES (nonzero), go to RESP with resp_err=1.
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits wide.
- RESP:
  - resp_valid=1 and all resp_* are stable until resp_ready; then go to IDLE.
- Alignment rules: LB/LBU/SB accept any address. LH/LHU/SH require addr[0]=0. LW/SW require addr[1:0]=00.
- Byte enables and store data (o = addr[1:0]):
  - SB: mem_be=0001<<o, mem_wdata={4{wdata[7:0]}}.
  - SH: mem_be=0011<<o, mem_wdata={2{wdata[15:0]}}.
  - SW: mem_be=1111.
  - Loads drive mem_be=1111.
- Load extraction: select byte lane o or halfword lane o[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_err=1 at completion: resp_err=1 and resp_rdata=0.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and any bus transaction in flight is abandoned. A mem_rvalid arriving later while in IDLE is ignored.

## Timing
- Reset values: req_ready=1; every other output is 0 (mem_*, resp_*, busy).
- Minimum latency (mem_ready and mem_rvalid each asserted at the earliest cycle):
  - cycle 0: accept;
  - cycle 1: REQ;
  - cycle 2: WAIT, mem_rvalid seen;
  - cycle 3: resp_valid.
- Error or trap without a bus access: resp_valid at cycle 1.
- Throughput: at most one operation per 2 cycles, because req_ready is 0 while RESP is held.
- All outputs are registered or decoded from state only. There is no combinational path from any input to req_ready or mem_valid.
- mem_rvalid asserted in the same cycle as mem_ready is not accepted; completion is sampled in WAIT only.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: a misaligned access raises resp_misalign=1, makes no bus access, and returns resp_rdata=0.
- LSU_MISALIGN_TRAP_EN not defined: address low bits are cleared to natural alignment (addr & ~(size-1)) and the access proceeds normally; resp_misalign is tied to 0.

## Test plan
- LBU addr 0x1003, mem_rdata 0x80FF_1234 → mem_be=1111, resp_rdata=0x0000_0080, resp_rd echoed, resp_valid at cycle 3.
- LH addr 0x2002, mem_rdata 0xF00D_0000 → resp_rdata=0xFFFF_F00D.
- SH addr 0x3002, wdata 0xAAAA_BEEF → mem_we=1, mem_addr=0x3000, mem_be=1100, mem_wdata=0xBEEF_BEEF; resp_rdata=0.
- LW addr 0x4001 → with the macro: resp_misalign=1, mem_valid never asserted. Without it: mem_addr=0x4000, normal response.
- TIMEOUT_CYCLES=4, mem_rvalid never asserted → resp_err=1 after exactly 4 WAIT cycles; funct3=011 load → resp_err=1 at cycle 1.
- rst_n deasserted during WAIT → all outputs return to reset values within the same cycle; a late mem_rvalid is ignored; the next request completes correctly.

Source files
------------

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one LOAD/STORE at a time over a valid/ready data bus,
// with completion timeout and load extension. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module riscv_lsu #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              resp_misalign,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err,
  output logic              busy
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                store_q, store_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [4:0]          rd_q, rd_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                req_illegal;
  logic [ADDR_W-1:0]   req_addr_al;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                misalign_q, misalign_d;
  logic                req_misalign;
  assign req_misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'b10 && (|req_addr[1:0]));
`endif

  // Latched address is already naturally aligned; with the trap enabled a misaligned one never reaches REQ.
  always_comb begin
    req_illegal = req_store ? (req_funct3 >= 3'b011)
                            : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    req_addr_al = req_addr;
    case (req_funct3[1:0])
      2'b01:   req_addr_al[0]   = 1'b0;
      2'b10:   req_addr_al[1:0] = 2'b00;
      default: ;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = mem_rdata;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      store_q    <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      rd_q       <= 5'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + CNT_W'(1);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      S_IDLE: if (req_valid) begin
        store_d  = req_store;
        funct3_d = req_funct3;
        addr_d   = req_addr_al;
        wdata_d  = req_wdata;
        rd_d     = req_rd;
        rdata_d  = 32'd0;
        err_d    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
        if (req_illegal) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (req_misalign) begin
          misalign_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          state_d = S_REQ;
        end
`else
        if (req_illegal) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_REQ;
        end
`endif
      end
      S_REQ: if (mem_ready) begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      // Completion wins over a timeout expiring in the same cycle.
      S_WAIT: if (mem_rvalid) begin
        err_d   = mem_err;
        rdata_d = (mem_err || store_q) ? 32'd0 : ld_data;
        state_d = S_RESP;
      end else if (TIMEOUT_CYCLES != 0) begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    mem_valid  = (state_q == S_REQ);
    resp_valid = (state_q == S_RESP);
    mem_we     = mem_valid & store_q;
    mem_addr   = mem_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_be     = 4'h0;
    mem_wdata  = 32'd0;
    if (mem_valid) begin
      mem_be    = 4'hF;
      mem_wdata = wdata_q;
      if (store_q) begin
        case (funct3_q[1:0])
          2'b00: begin
            mem_be    = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            mem_be    = 4'b0011 << addr_q[1:0];
            mem_wdata = {2{wdata_q[15:0]}};
          end
          default: ;
        endcase
      end
    end
    resp_rdata = resp_valid ? rdata_q : 32'd0;
    resp_rd    = resp_valid ? rd_q : 5'd0;
    resp_err   = resp_valid & err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    resp_misalign = resp_valid & misalign_q;
`else
    resp_misalign = 1'b0;
`endif
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: fixed vectors, hand sequences for timeout/reset corners,
// and random operations checked against an arithmetic reference model.
module tb_riscv_lsu;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [4:0]    req_rd = '0;
  logic          req_ready, resp_valid, resp_err, resp_misalign, busy;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_rdata;
  logic [4:0]    resp_rd;
  logic          mem_valid, mem_we;
  logic          mem_ready = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  riscv_lsu #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err), .resp_misalign(resp_misalign),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy)
  );

  typedef struct {
    bit        store;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [4:0]  rd;
    bit [31:0] mrdata;
    bit        merr;
    int        rdly;
    int        vdly;
    int        rsp_dly;
    bit        early_rv;
  } op_t;

  typedef struct {
    bit        mem;
    bit        we;
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata;
    bit [31:0] rdata;
    bit        err;
    bit        mis;
    int        lat;
  } exp_t;

  typedef struct {
    bit        saw_mem;
    bit        we;
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata;
    bit [31:0] rdata;
    bit [4:0]  rd;
    bit        err;
    bit        mis;
    bit        got_resp;
    bit        unstable;
    bit        timed_out;
    bit        idle_after;
    int        lat;
  } obs_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  int tests = 0;
  int failed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic op_t mk(bit store, bit [2:0] f3, bit [31:0] addr, bit [31:0] wdata,
                             bit [4:0] rd, bit [31:0] mrdata, bit merr, int rdly, int vdly);
    op_t o;
    o.store = store; o.f3 = f3; o.addr = addr; o.wdata = wdata; o.rd = rd;
    o.mrdata = mrdata; o.merr = merr; o.rdly = rdly; o.vdly = vdly;
    o.rsp_dly = 0; o.early_rv = 1'b0;
    return o;
  endfunction

  function automatic exp_t mkexp(bit mem, bit we, bit [31:0] addr, bit [3:0] be,
                                 bit [31:0] wdata, bit [31:0] rdata, bit err, int lat);
    exp_t e;
    e.mem = mem; e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
    e.rdata = rdata; e.err = err; e.mis = 1'b0; e.lat = lat;
    return e;
  endfunction

  // Reference: sizes, offsets and extension derived arithmetically from the ISA rules.
  function automatic exp_t model(op_t op);
    exp_t e;
    int size, off, lane;
    bit [31:0] eff;
    longint v, full;
    bit illegal;
    e = '{default: 0};
    illegal = op.store ? (op.f3 > 3'd2) : (op.f3 == 3'd3 || op.f3 > 3'd5);
    if (illegal) begin
      e.err = 1'b1; e.lat = 1;
      return e;
    end
    size = 1 << op.f3[1:0];
    off  = int'(op.addr % size);
`ifdef LSU_MISALIGN_TRAP_EN
    if (off != 0) begin
      e.mis = 1'b1; e.lat = 1;
      return e;
    end
`endif
    eff    = op.addr - off;
    lane   = int'(eff % 4);
    e.mem  = 1'b1;
    e.we   = op.store;
    e.addr = eff - lane;
    e.be   = op.store ? 4'(((1 << size) - 1) << lane) : 4'hF;
    e.wdata = (size == 1) ? op.wdata[7:0] * 32'h0101_0101 :
              (size == 2) ? op.wdata[15:0] * 32'h0001_0001 : op.wdata;
    if (op.vdly < 0 || op.vdly >= TO) begin
      e.err = 1'b1; e.lat = 2 + op.rdly + TO;
      return e;
    end
    e.lat = 3 + op.rdly + op.vdly;
    if (op.merr) e.err = 1'b1;
    else if (!op.store) begin
      full = longint'(1) << (8 * size);
      v = (longint'(op.mrdata) >> (8 * lane)) % full;
      if (!op.f3[2] && v >= full / 2) v = v - full;
      e.rdata = v[31:0];
    end
    return e;
  endfunction

  // Drives one operation from a negedge and acts as the bus slave; returns what it saw.
  task automatic run_op(input op_t op, output obs_t ob);
    int cyc = 0, req_seen = 0, wcnt = 0, rsp_wait = 0;
    bit in_wait = 0, done = 0;
    ob = '{default: 0};
    req_valid = 1'b1; req_store = op.store; req_funct3 = op.f3;
    req_addr = op.addr; req_wdata = op.wdata; req_rd = op.rd;
    while (!done && cyc < 60) begin
      @(posedge clk); @(negedge clk); cyc++;
      req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
      mem_rdata = $urandom; resp_ready = 1'b0;
      if (resp_valid) begin
        if (!ob.got_resp) begin
          ob.got_resp = 1'b1; ob.lat = cyc; ob.rdata = resp_rdata; ob.rd = resp_rd;
          ob.err = resp_err; ob.mis = resp_misalign;
        end else if (resp_rdata != ob.rdata || resp_rd != ob.rd ||
                     resp_err != ob.err || resp_misalign != ob.mis) ob.unstable = 1'b1;
        if (rsp_wait == op.rsp_dly) begin
          resp_ready = 1'b1; done = 1'b1;
        end
        rsp_wait++;
      end else if (in_wait) begin
        if (wcnt == op.vdly) begin
          mem_rvalid = 1'b1; mem_rdata = op.mrdata; mem_err = op.merr;
        end
        wcnt++;
      end else if (mem_valid) begin
        if (!ob.saw_mem) begin
          ob.saw_mem = 1'b1; ob.we = mem_we; ob.addr = mem_addr; ob.be = mem_be; ob.wdata = mem_wdata;
        end else if (mem_we != ob.we || mem_addr != ob.addr || mem_be != ob.be ||
                     mem_wdata != ob.wdata) ob.unstable = 1'b1;
        if (req_seen == op.rdly) begin
          mem_ready = 1'b1; in_wait = 1'b1;
          if (op.early_rv) begin
            mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h0BAD_0BAD;
          end
        end
        req_seen++;
      end
    end
    ob.timed_out = !done;
    if (done) begin
      @(posedge clk); @(negedge clk);
      resp_ready = 1'b0;
      ob.idle_after = req_ready;
    end
  endtask

  task automatic compare(input string tag, input op_t op, input obs_t ob, input exp_t e);
    chk({tag, "_budget"}, ob.timed_out, 0);
    chk({tag, "_lat"}, ob.lat, e.lat);
    chk({tag, "_mem"}, ob.saw_mem, e.mem);
    if (e.mem) begin
      chk({tag, "_addr"}, ob.addr, e.addr);
      chk({tag, "_be"}, ob.be, e.be);
      chk({tag, "_we"}, ob.we, e.we);
      if (op.store) chk({tag, "_wdata"}, ob.wdata, e.wdata);
    end
    chk({tag, "_rdata"}, ob.rdata, e.rdata);
    chk({tag, "_rd"}, ob.rd, op.rd);
    chk({tag, "_err"}, ob.err, e.err);
    chk({tag, "_mis"}, ob.mis, e.mis);
    chk({tag, "_stable"}, ob.unstable, 0);
    chk({tag, "_idle"}, ob.idle_after, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    op_t  op;
    obs_t ob;
    exp_t e;

    vecs[0] = '{mk(0, 3'b100, 32'h1003, 0, 5'd7, 32'h80FF_1234, 0, 0, 0),
                mkexp(1, 0, 32'h1000, 4'hF, 0, 32'h0000_0080, 0, 3)};
    vecs[1] = '{mk(0, 3'b001, 32'h2002, 0, 5'd9, 32'hF00D_0000, 0, 0, 0),
                mkexp(1, 0, 32'h2000, 4'hF, 0, 32'hFFFF_F00D, 0, 3)};
    vecs[2] = '{mk(1, 3'b001, 32'h3002, 32'hAAAA_BEEF, 5'd3, 32'h1111_1111, 0, 0, 0),
                mkexp(1, 1, 32'h3000, 4'b1100, 32'hBEEF_BEEF, 0, 0, 3)};
    vecs[3] = '{mk(0, 3'b000, 32'h0010, 0, 5'd31, 32'h0000_007F, 0, 0, 0),
                mkexp(1, 0, 32'h0010, 4'hF, 0, 32'h0000_007F, 0, 3)};
    vecs[4] = '{mk(0, 3'b000, 32'h0011, 0, 5'd1, 32'h0000_8000, 0, 0, 0),
                mkexp(1, 0, 32'h0010, 4'hF, 0, 32'hFFFF_FF80, 0, 3)};
    vecs[5] = '{mk(0, 3'b101, 32'h0022, 0, 5'd2, 32'h8001_0000, 0, 0, 0),
                mkexp(1, 0, 32'h0020, 4'hF, 0, 32'h0000_8001, 0, 3)};
    vecs[6] = '{mk(0, 3'b010, 32'h0040, 0, 5'd4, 32'hDEAD_BEEF, 0, 2, 3),
                mkexp(1, 0, 32'h0040, 4'hF, 0, 32'hDEAD_BEEF, 0, 8)};
    vecs[7] = '{mk(1, 3'b000, 32'h0053, 32'h1234_5678, 5'd5, 0, 0, 1, 1),
                mkexp(1, 1, 32'h0050, 4'b1000, 32'h7878_7878, 0, 0, 5)};
    vecs[8] = '{mk(1, 3'b010, 32'h0060, 32'hCAFE_F00D, 5'd6, 0, 0, 0, 0),
                mkexp(1, 1, 32'h0060, 4'hF, 32'hCAFE_F00D, 0, 0, 3)};
    vecs[9] = '{mk(0, 3'b010, 32'h0070, 0, 5'd8, 32'h1234_5678, 1, 0, 0),
                mkexp(1, 0, 32'h0070, 4'hF, 0, 0, 1, 3)};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_outs", {mem_we, mem_addr, mem_be, mem_wdata}, 0);
    chk("rst_resp_outs", {resp_valid, resp_rdata, resp_rd, resp_err, resp_misalign}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, ob);
      compare($sformatf("vec%0d", i), vecs[i].op, ob, vecs[i].e);
    end

    // Misaligned word load
    op = mk(0, 3'b010, 32'h4001, 0, 5'd12, 32'h5555_AAAA, 0, 0, 0);
    run_op(op, ob);
`ifdef LSU_MISALIGN_TRAP_EN
    compare("lw_mis", op, ob, '{mem: 0, we: 0, addr: 0, be: 0, wdata: 0, rdata: 0, err: 0, mis: 1, lat: 1});
`else
    compare("lw_mis", op, ob, mkexp(1, 0, 32'h4000, 4'hF, 0, 32'h5555_AAAA, 0, 3));
`endif

    // Timeout: rvalid never arrives -> 1 REQ + 4 WAIT cycles
    op = mk(0, 3'b010, 32'h5000, 0, 5'd13, 0, 0, 0, -1);
    run_op(op, ob);
    compare("timeout", op, ob, mkexp(1, 0, 32'h5000, 4'hF, 0, 0, 1, 6));

    // Illegal funct3 load 011 -> error at cycle 1, no bus access
    op = mk(0, 3'b011, 32'h6000, 0, 5'd14, 0, 0, 0, 0);
    run_op(op, ob);
    compare("ill_ld", op, ob, mkexp(0, 0, 0, 0, 0, 0, 1, 1));

    // Illegal store funct3
    op = mk(1, 3'b100, 32'h6004, 32'hFFFF_FFFF, 5'd15, 0, 0, 0, 0);
    run_op(op, ob);
    compare("ill_st", op, ob, mkexp(0, 0, 0, 0, 0, 0, 1, 1));

    // rvalid alongside mem_ready must be ignored; completion comes from WAIT
    op = mk(0, 3'b010, 32'h7000, 0, 5'd16, 32'h0123_4567, 0, 0, 1);
    op.early_rv = 1'b1;
    op.rsp_dly = 2;
    run_op(op, ob);
    compare("early_rv", op, ob, mkexp(1, 0, 32'h7000, 4'hF, 0, 32'h0123_4567, 0, 4));

    // Reset asserted during WAIT
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_rd = 5'd20;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("mr_req_phase", mem_valid, 1);
    mem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    chk("mr_wait_busy", {busy, mem_valid}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req_ready", req_ready, 1);
    chk("mr_outs", {busy, mem_valid, mem_we, mem_addr, mem_be, mem_wdata, resp_valid, resp_rdata,
                    resp_rd, resp_err, resp_misalign}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFEED_FACE; mem_err = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0; mem_err = 1'b0;
    chk("mr_late_rvalid", {busy, resp_valid, req_ready}, 3'b001);
    op = mk(0, 3'b100, 32'h0202, 0, 5'd21, 32'h00C3_0000, 0, 0, 0);
    run_op(op, ob);
    compare("mr_next", op, ob, mkexp(1, 0, 32'h0200, 4'hF, 0, 32'h0000_00C3, 0, 3));

    // Random operations against the reference model
    for (int n = 0; n < 150; n++) begin
      op.store = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) op.f3 = 3'($urandom_range(0, 7));
      else if (op.store) op.f3 = 3'($urandom_range(0, 2));
      else begin
        op.f3 = 3'($urandom_range(0, 4));
        if (op.f3 == 3'd3) op.f3 = 3'd5;
      end
      op.addr     = $urandom;
      op.wdata    = $urandom;
      op.rd       = 5'($urandom_range(0, 31));
      op.mrdata   = $urandom;
      op.merr     = ($urandom_range(0, 7) == 0);
      op.rdly     = $urandom_range(0, 3);
      op.vdly     = $urandom_range(0, 6);
      if (op.vdly == 6) op.vdly = -1;
      op.rsp_dly  = $urandom_range(0, 2);
      op.early_rv = ($urandom_range(0, 3) == 0);
      e = model(op);
      run_op(op, ob);
      compare($sformatf("rnd%0d", n), op, ob, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
